// File: rtl/fft_buf_pkg.sv
// Shared types and helpers for the FFT spectrum capture buffer.
//   bank_state_t : occupancy of one ping-pong bank
//   rd_state_t   : readout FSM state
//   bitrev()     : reverses the low 'width' bits of a value
package fft_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        READING = 2'd2
    } bank_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    localparam int unsigned NUM_BANKS = 2;

    // Bits at and above 'width' are returned as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned j = 0; j < 32; j++) begin
            if (j < width) begin
                r[j] = value[5'(width - 1 - j)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_buf_sdp_ram.sv
// Simple dual-port RAM holding both ping-pong banks (bank bit is the address MSB).
// Ports:
//   clk          clock
//   we/waddr/wdata  capture-side write port
//   re/raddr     readout-side read port; rdata is registered and only
//                updates when re is high (acts as the first pipeline stage)
module fft_buf_sdp_ram #(
    parameter int unsigned W  = 16,
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_spectrum_buffer.sv
// Capture buffer for FFT magnitude frames. Reorders (optionally bit-reversed)
// FFT output into natural bin order across two ping-pong banks and streams
// completed frames out on a valid/ready interface.
// Optional feature macro: FFT_PEAK_TRACK_EN (per-frame peak magnitude/bin).
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   mag, mag_valid   input samples; mag_valid held high for the whole frame
//   out_data/out_bin/out_last/out_valid/out_ready  readout stream
//   frame_drop_cnt   saturating count of frames dropped for lack of a bank
//   peak_mag/peak_bin/peak_valid  frame peak (zero without the macro)
module fft_spectrum_buffer
    import fft_buf_pkg::*;
#(
    parameter int unsigned NSamples        = 1024,
    parameter int unsigned W               = 16,
    parameter int unsigned KEEP_NEG        = 0,
    parameter int unsigned BIT_REVERSED_IN = 1,
    parameter int unsigned DROP_CNT_W      = 16,
    localparam int unsigned NBits = $clog2(NSamples),
    localparam int unsigned D     = (KEEP_NEG != 0) ? NSamples : NSamples / 2,
    localparam int unsigned DBits = $clog2(D)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          mag,
    input  logic                  mag_valid,
    output logic [W-1:0]          out_data,
    output logic [DBits-1:0]      out_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [DROP_CNT_W-1:0] frame_drop_cnt,
    output logic [W-1:0]          peak_mag,
    output logic [DBits-1:0]      peak_bin,
    output logic                  peak_valid
);

    // Capture side
    logic [NBits-1:0] cap_idx;
    logic             cap_bank;
    logic             cap_drop;
    logic             start_frame;
    logic             last_beat;
    logic             sel_bank;
    logic             sel_ok;
    logic             cur_bank;
    logic             cur_drop;
    logic [NBits-1:0] k;
    logic             wr_en;
    logic [DBits:0]   wr_addr;
    logic             commit;
    logic             drop_inc;

    // Bank bookkeeping
    bank_state_t      bank_state [NUM_BANKS];
    logic             fifo_q0;
    logic             fifo_q1;
    logic [1:0]       fifo_cnt;

    // Readout side
    rd_state_t        rd_state;
    rd_state_t        rd_state_nxt;
    logic             release_bank;
    logic             start_rd;
    logic             rd_bank;
    logic [DBits-1:0] rd_cnt;
    logic             issue_done;
    logic             issue;
    logic             iss_bank;
    logic [DBits-1:0] iss_bin;
    logic             s1_valid;
    logic [DBits-1:0] s1_bin;
    logic             s1_last;
    logic             s1_accept;
    logic             out_load;
    logic [W-1:0]     ram_q;

    // ---------------------------------------------------------------
    // Capture: bank choice at frame start comes from registered state,
    // so a bank released this cycle is only seen by the next frame.
    // ---------------------------------------------------------------
    always_comb begin
        start_frame = mag_valid && (cap_idx == '0);
        last_beat   = mag_valid && (cap_idx == NBits'(NSamples - 1));
        sel_ok      = (bank_state[0] == EMPTY) || (bank_state[1] == EMPTY);
        sel_bank    = (bank_state[0] == EMPTY) ? 1'b0 : 1'b1;
        cur_bank    = start_frame ? sel_bank : cap_bank;
        cur_drop    = start_frame ? !sel_ok : cap_drop;
        k           = (BIT_REVERSED_IN != 0) ? NBits'(bitrev(32'(cap_idx), NBits)) : cap_idx;
        wr_en       = mag_valid && !cur_drop && (32'(k) < D);
        wr_addr     = {cur_bank, k[DBits-1:0]};
        commit      = last_beat && !cur_drop;
        drop_inc    = last_beat && cur_drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_idx  <= '0;
            cap_bank <= 1'b0;
            cap_drop <= 1'b0;
        end else if (!mag_valid) begin
            // A gap aborts any partial frame; its bank was never marked used.
            cap_idx <= '0;
        end else begin
            if (start_frame) begin
                cap_bank <= sel_bank;
                cap_drop <= !sel_ok;
            end
            cap_idx <= (cap_idx == NBits'(NSamples - 1)) ? '0 : cap_idx + NBits'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_drop_cnt <= '0;
        end else if (drop_inc && (frame_drop_cnt != '1)) begin
            frame_drop_cnt <= frame_drop_cnt + DROP_CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Bank state and commit-order FIFO. Commit, read start and release
    // always touch different banks, so all three may occur together.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                bank_state[b] <= EMPTY;
            end
        end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (commit && (32'(cur_bank) == b)) begin
                    bank_state[b] <= FULL;
                end else if (start_rd && (32'(fifo_q0) == b)) begin
                    bank_state[b] <= READING;
                end else if (release_bank && (32'(rd_bank) == b)) begin
                    bank_state[b] <= EMPTY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_q0  <= 1'b0;
            fifo_q1  <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            case ({commit, start_rd})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        fifo_q0 <= cur_bank;
                    end else begin
                        fifo_q1 <= cur_bank;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    fifo_q0  <= fifo_q1;
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        fifo_q0 <= cur_bank;
                    end else begin
                        fifo_q0 <= fifo_q1;
                        fifo_q1 <= cur_bank;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Read FSM and three-stage pipeline: address issue -> RAM register
    // (s1) -> output register. Bin 0 is issued in the same cycle the FSM
    // starts a bank, giving out_valid two cycles after commit.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= IDLE;
        end else begin
            rd_state <= rd_state_nxt;
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        release_bank = (rd_state == READ) && out_valid && out_ready && out_last;
        start_rd     = (fifo_cnt != 2'd0) && ((rd_state == IDLE) || release_bank);
        case (rd_state)
            IDLE: if (start_rd) rd_state_nxt = READ;
            READ: if (release_bank && !start_rd) rd_state_nxt = IDLE;
            default: rd_state_nxt = IDLE;
        endcase
        out_load  = s1_valid && (!out_valid || out_ready);
        s1_accept = !s1_valid || out_load;
        issue     = s1_accept && (start_rd || ((rd_state == READ) && !issue_done));
        iss_bank  = start_rd ? fifo_q0 : rd_bank;
        iss_bin   = start_rd ? '0 : rd_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_bank    <= 1'b0;
            rd_cnt     <= '0;
            issue_done <= 1'b0;
            s1_valid   <= 1'b0;
            s1_bin     <= '0;
            s1_last    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_bin    <= '0;
            out_last   <= 1'b0;
        end else begin
            if (start_rd) begin
                rd_bank    <= fifo_q0;
                rd_cnt     <= issue ? DBits'(1) : '0;
                issue_done <= 1'b0;
            end else if (issue) begin
                rd_cnt     <= rd_cnt + DBits'(1);
                issue_done <= (rd_cnt == DBits'(D - 1));
            end

            if (issue) begin
                s1_valid <= 1'b1;
                s1_bin   <= iss_bin;
                s1_last  <= (iss_bin == DBits'(D - 1));
            end else if (out_load) begin
                s1_valid <= 1'b0;
            end

            if (out_load) begin
                out_valid <= 1'b1;
                out_data  <= ram_q;
                out_bin   <= s1_bin;
                out_last  <= s1_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    fft_buf_sdp_ram #(
        .W  (W),
        .AW (DBits + 1)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (mag),
        .re    (issue),
        .raddr ({iss_bank, iss_bin}),
        .rdata (ram_q)
    );

    // ---------------------------------------------------------------
    // Optional peak tracker. Comparing on bin index (not arrival order)
    // makes ties resolve to the lowest bin for any input ordering.
    // ---------------------------------------------------------------
`ifdef FFT_PEAK_TRACK_EN
    logic [W-1:0]     trk_mag;
    logic [W-1:0]     trk_mag_nxt;
    logic [DBits-1:0] trk_bin;
    logic [DBits-1:0] trk_bin_nxt;
    logic             trk_any;
    logic             trk_any_nxt;

    always_comb begin
        trk_mag_nxt = start_frame ? '0 : trk_mag;
        trk_bin_nxt = start_frame ? '0 : trk_bin;
        trk_any_nxt = start_frame ? 1'b0 : trk_any;
        if (wr_en && (k != '0)) begin
            if (!trk_any_nxt || (mag > trk_mag_nxt) ||
                ((mag == trk_mag_nxt) && (k[DBits-1:0] < trk_bin_nxt))) begin
                trk_mag_nxt = mag;
                trk_bin_nxt = k[DBits-1:0];
                trk_any_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trk_mag    <= '0;
            trk_bin    <= '0;
            trk_any    <= 1'b0;
            peak_mag   <= '0;
            peak_bin   <= '0;
            peak_valid <= 1'b0;
        end else begin
            trk_mag    <= trk_mag_nxt;
            trk_bin    <= trk_bin_nxt;
            trk_any    <= trk_any_nxt;
            peak_valid <= commit;
            if (commit) begin
                peak_mag <= trk_mag_nxt;
                peak_bin <= trk_bin_nxt;
            end
        end
    end
`else
    assign peak_mag   = '0;
    assign peak_bin   = '0;
    assign peak_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fft_spectrum_buffer.sv
`timescale 1ns/1ps
module tb_fft_spectrum_buffer;

    localparam int NS = 16;
    localparam int DD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] mag;
    logic       mag_valid;
    logic [7:0] out_data;
    logic [2:0] out_bin;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [15:0] frame_drop_cnt;
    logic [7:0] peak_mag;
    logic [2:0] peak_bin;
    logic       peak_valid;

    always #5 clk = ~clk;

    fft_spectrum_buffer #(
        .NSamples        (16),
        .W               (8),
        .KEEP_NEG        (0),
        .BIT_REVERSED_IN (1),
        .DROP_CNT_W      (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mag            (mag),
        .mag_valid      (mag_valid),
        .out_data       (out_data),
        .out_bin        (out_bin),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .frame_drop_cnt (frame_drop_cnt),
        .peak_mag       (peak_mag),
        .peak_bin       (peak_bin),
        .peak_valid     (peak_valid)
    );

    typedef struct {
        logic [7:0] data;
        logic [2:0] bin;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] beat_val [NS];
    int         total = 0;
    int         bad = 0;
    int         held = 0;       // frames committed and not yet fully delivered
    int         exp_drop = 0;
    int         beats_seen = 0;
    int         rdy_mode = 1;   // 0 low, 1 high, 2 toggle, 3 random
    bit         bin3_flag = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference bit reversal over 4 bits, by arithmetic.
    function automatic int rev4(input int v);
        int r = 0;
        int x = v;
        for (int b = 0; b < 4; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    // Drives n_beats of beat_val; a full frame is modelled as kept (queued
    // in natural bin order) or dropped depending on bank occupancy at start.
    task automatic send_frame(input int n_beats);
        bit         drop;
        logic [7:0] nat [DD];
        drop = (held >= 2);
        for (int i = 0; i < n_beats; i++) begin
            mag       = beat_val[i];
            mag_valid = 1'b1;
            @(posedge clk); #1;
        end
        mag_valid = 1'b0;
        mag       = '0;
        if (n_beats == NS) begin
            if (drop) begin
                exp_drop++;
            end else begin
                for (int i = 0; i < NS; i++) begin
                    if (rev4(i) < DD) nat[rev4(i)] = beat_val[i];
                end
                for (int b = 0; b < DD; b++) begin
                    exp_q.push_back('{data: nat[b], bin: 3'(b), last: (b == DD - 1)});
                end
                held++;
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NS; i++) beat_val[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                2: out_ready = ~out_ready;
                default: out_ready = ($urandom_range(0, 99) < 70);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks that a
    // stalled beat stays put.
    initial begin
        beat_t      e;
        logic [7:0] sd;
        logic [2:0] sb;
        logic       sl;
        bit         stall = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 0;
            end else begin
                if (stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, sd);
                    check("hold_bin", out_bin, sb);
                    check("hold_last", out_last, sl);
                end
                stall = out_valid && !out_ready;
                sd = out_data;
                sb = out_bin;
                sl = out_last;
                if (out_valid && out_ready) begin
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got bin %0d data %0d, expected no beat", out_bin, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", out_data, e.data);
                        check("beat_bin", out_bin, e.bin);
                        check("beat_last", out_last, e.last);
                        if (e.last) held--;
                        if (e.bin == 3'd3) bin3_flag = 1;
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bs0;
        int n;
        reset     = 1'b1;
        mag       = '0;
        mag_valid = 1'b0;
        idle(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_drop_cnt", frame_drop_cnt, 0);
        check("rst_peak_valid", peak_valid, 0);
        reset = 1'b0;
        idle(2);

        // Single frame, latency
        for (int i = 0; i < NS; i++) beat_val[i] = 8'(2 * rev4(i));
        send_frame(NS);
        check("lat_r0", out_valid, 0);
        @(posedge clk); #1;
        check("lat_r1", out_valid, 0);
        @(posedge clk); #1;
        check("lat_r2", out_valid, 1);
        check("first_bin", out_bin, 0);
        drain(100);

        // Backpressure with alternating ready
        rdy_mode = 2;
        bs0 = beats_seen;
        send_frame(NS);
        drain(200);
        check("bp_beat_count", beats_seen - bs0, DD);
        rdy_mode = 1;
        idle(4);

        // Overflow: three frames, no readout
        rdy_mode = 0;
        idle(2);
        fill_random(); send_frame(NS);
        fill_random(); send_frame(NS);
        fill_random(); send_frame(NS);
        check("ovf_drop_cnt", frame_drop_cnt, exp_drop);
        check("ovf_drop_one", frame_drop_cnt, 1);
        check("ovf_stalled_valid", out_valid, 1);
        rdy_mode = 1;
        drain(300);
        idle(4);

        // Abort after 5 beats, then a full frame
        fill_random(); send_frame(5);
        idle(3);
        fill_random(); send_frame(NS);
        drain(200);
        check("abort_drop_cnt", frame_drop_cnt, exp_drop);
        idle(4);

        // Reset during readout after bin 3
        bin3_flag = 0;
        fill_random(); send_frame(NS);
        n = 0;
        while (!bin3_flag && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bin3_seen", bin3_flag, 1);
        reset = 1'b1;
        exp_q.delete();
        held     = 0;
        exp_drop = 0;
        @(posedge clk); #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_drop", frame_drop_cnt, 0);
        reset = 1'b0;
        idle(2);
        fill_random(); send_frame(NS);
        drain(200);

        // Randomized traffic
        rdy_mode = 3;
        for (int f = 0; f < 10; f++) begin
            fill_random();
            if ($urandom_range(0, 3) == 0) begin
                send_frame(int'($urandom_range(1, NS - 1)));
                idle(int'($urandom_range(1, 3)));
            end else begin
                send_frame(NS);
                if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(0, 12)));
            end
        end
        rdy_mode = 1;
        drain(2000);

`ifdef FFT_PEAK_TRACK_EN
        begin
            logic [7:0] nat [DD];
            for (int b = 0; b < DD; b++) nat[b] = 8'd10;
            nat[0] = 8'd255;
            nat[3] = 8'd200;
            nat[5] = 8'd200;
            for (int i = 0; i < NS; i++) begin
                beat_val[i] = (rev4(i) < DD) ? nat[rev4(i)] : 8'($urandom_range(0, 255));
            end
            send_frame(NS);
            check("peak_valid_pulse", peak_valid, 1);
            check("peak_mag", peak_mag, 200);
            check("peak_bin", peak_bin, 3);
            @(posedge clk); #1;
            check("peak_valid_clear", peak_valid, 0);
            check("peak_mag_hold", peak_mag, 200);
            drain(200);
        end
`else
        check("peak_mag_zero", peak_mag, 0);
        check("peak_bin_zero", peak_bin, 0);
        check("peak_valid_zero", peak_valid, 0);
`endif

        idle(6);
        check("final_drop_cnt", frame_drop_cnt, exp_drop);
        check("final_idle_valid", out_valid, 0);
        check("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_spectrum_buffer.md
Name: fft_spectrum_buffer

Overview:
Parametrised capture buffer for FFT magnitude frames. It reorders bit-reversed FFT output into natural bin order and holds completed frames in two ping-pong banks. Frames are streamed out on a valid/ready interface with bin index and last flag, so capture of frame N+1 overlaps readout of frame N. It sits between the FFT magnitude stage and downstream consumers (display overlay, SignalTap probe, peak logic).

Parameters:
- NSamples, 1024, FFT frame length; power of 2, at least 8.
- W, 16, magnitude width.
- KEEP_NEG, 0, selects bins stored. 0 stores the positive half (D = NSamples/2). 1 stores all bins (D = NSamples).
- BIT_REVERSED_IN, 1, input order. 1 means the input arrives in bit-reversed order. 0 means natural order.
- DROP_CNT_W, 16, width of the dropped-frame counter.
- Derived: NBits = $clog2(NSamples); DBits = $clog2(D).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mag  in  W  FFT magnitude sample
- mag_valid  in  1  sample strobe; must stay high for the whole frame
- out_data  out  W  magnitude in natural bin order
- out_bin  out  DBits  bin index of out_data
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_last  out  1  high on bin D-1
- frame_drop_cnt  out  DROP_CNT_W  saturating count of dropped frames
- peak_mag  out  W  frame peak magnitude (optional feature)
- peak_bin  out  DBits  bin of the frame peak (optional feature)
- peak_valid  out  1  one-cycle pulse, peak updated (optional feature)

Behaviour:
- Reset: all outputs 0, both banks EMPTY, capture index i = 0, read FSM in IDLE. Reset mid-frame or mid-readout discards all content; out_valid is 0 in the cycle after reset is sampled.
- Capture:
  - i counts 0..NSamples-1, advancing on each mag_valid cycle.
  - Address k = bitrev(i) when BIT_REVERSED_IN=1, otherwise k = i.
  - A sample is written to the capture bank only when k < D.
- Abort: mag_valid low while i != 0 resets i to 0. The partial frame is discarded and the bank stays EMPTY.
- Frame start (i == 0 with mag_valid high):
  - The bank is chosen from registered bank state, lowest-numbered EMPTY bank first.
  - If no bank is EMPTY, the whole frame is dropped: no writes, and frame_drop_cnt increments (saturating) on its last beat.
  - A bank released in cycle t is usable only by a frame starting at t+1 or later.
- Commit: on the beat with i == NSamples-1, the capture bank becomes FULL and is queued for readout (FIFO order of banks). i wraps to 0; back-to-back frames need no idle cycle.
- Read FSM:
  - IDLE to READ when any bank is FULL. That bank becomes READING.
  - RAM read latency is 1 cycle, followed by an output register. The first out_valid occurs 2 cycles after commit when the reader is idle.
  - Bins are emitted 0..D-1 ascending.
  - Standard valid/ready: out_data, out_bin and out_last are held stable while out_valid && !out_ready. No beat is lost or duplicated.
  - Handshake on out_last releases the bank to EMPTY in the same cycle. The FSM then goes to READ if another bank is FULL, otherwise IDLE.
- Simultaneous commit and release in the same cycle: both take effect.

Optional Feature:
- Macro: FFT_PEAK_TRACK_EN.
- With the macro defined:
  - Tracks the maximum magnitude over stored bins, excluding bin 0 (DC).
  - Ties resolve to the lowest bin index, independent of arrival order.
  - At commit, peak_mag and peak_bin are registered and peak_valid pulses for 1 cycle. Values hold until the next commit.
  - Dropped or aborted frames produce no update.
- Without the macro: peak logic is not built, and peak_mag, peak_bin and peak_valid are tied to 0.

Decomposition:
- Package fft_buf_pkg holds:
  - the bitrev function, parametrised by width;
  - the bank_state_t enum {EMPTY, FULL, READING};
  - the rd_state_t enum {IDLE, READ}.
- Sub-module fft_buf_sdp_ram: simple dual-port RAM of 2*D x W with 1-cycle registered read. The bank bit is the address MSB. It has one write port (capture side) and one read port (readout side).

Test Plan (NSamples=16, W=8, KEEP_NEG=0, BIT_REVERSED_IN=1):
- Single frame: beat i carries mag = 2*bitrev(i), out_ready=1 -> out_data 0,2,...,14 with out_bin 0..7; out_last only on bin 7; first out_valid 2 cycles after the last input beat.
- Backpressure: same frame with out_ready pattern 1,0,1,0,... -> each beat held while ready is low; exactly 8 beats delivered, in order.
- Overflow: three back-to-back frames (values A, B, C) with out_ready=0 -> frame_drop_cnt=1 after frame 3. Then out_ready=1 -> A bins 0..7, then B bins 0..7; C is never output.
- Abort: mag_valid drops after 5 beats, then a full frame D follows -> no output from the partial frame; frame D read correctly; frame_drop_cnt unchanged.
- Reset mid-readout after bin 3 -> out_valid=0 the next cycle, frame_drop_cnt=0, banks empty. The next full frame reads correctly from bin 0.
- Peak (FFT_PEAK_TRACK_EN): bins 3 and 5 = 200, bin 0 = 255, others 10 -> peak_bin=3, peak_mag=200, peak_valid high for exactly 1 cycle at commit.
